ram_write_port_arbiter: RTL and testbench
=========================================

// Module: ram_write_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of RAM_DUAL_READ_PORT among NUM_REQ writers
//  (e.g. memory-bus loader, ALU result path, control unit). Supports locked bursts (one owner,
//  back-to-back writes). Exports the in-flight write so read sequencers stall on RAW hazards.
// PARAMETERS
//  NUM_REQ     4                   number of write requesters (>=2)
//  DATA_WIDTH  `DATA_ROW_WIDTH     write data width
//  ADDR_WIDTH  `DATA_ADDRESS_WIDTH RAM address width
// PORTS
//  Clock              in   1                    single clock, rising edge
//  Reset              in   1                    synchronous, active-low
//  iWriteRequest      in   NUM_REQ              per-requester write request, held until granted
//  iWriteLock         in   NUM_REQ              with request: keep ownership after this beat
//  iWriteAddress      in   NUM_REQ*ADDR_WIDTH   flattened; slice i = requester i
//  iWriteData         in   NUM_REQ*DATA_WIDTH   flattened; slice i = requester i
//  oWriteGrant        out  NUM_REQ              one-hot/zero, combinational; accept at this edge
//  oRamWriteEnable    out  1                    registered, to RAM iWriteEnable
//  oRamWriteAddress   out  ADDR_WIDTH           registered, to RAM iWriteAddress
//  oRamDataIn         out  DATA_WIDTH           registered, to RAM iDataIn
//  oInFlightValid     out  1                    == oRamWriteEnable (write lands at next edge)
//  oInFlightAddress   out  ADDR_WIDTH           == oRamWriteAddress
//  oLocked            out  1                    registered, FSM in LOCKED
//  oOwner             out  $clog2(NUM_REQ)      registered, last granted requester
// BEHAVIOUR
//  - Reset (Reset==0 at edge): FSM=ARB, pointer=NUM_REQ-1 (requester 0 highest first), all
//    registered outputs 0. Reset overrides any grant; in-progress lock is dropped; oWriteGrant=0
//    while Reset==0.
//  - ARB: grant lowest index i with iWriteRequest[i], searching circularly from pointer+1.
//    At edge with grant i: pointer<=i, oOwner<=i, oRamWriteEnable<=1, addr/data <= slice i.
//    If iWriteLock[i]==1 -> LOCKED. No request -> oRamWriteEnable<=0, pointer unchanged.
//  - LOCKED: only oOwner may be granted. Owner request -> grant, one write per cycle; grant with
//    iWriteLock==0 is last beat -> ARB. Owner idle -> no grant, oRamWriteEnable<=0, stay LOCKED.
//    Other requests wait; no timeout.
//  - At most one grant bit per cycle; grant is a pure function of state and current requests.
//  - Latency: grant cycle T -> RAM write controls valid cycle T+1 -> RAM array updated at end of
//    T+1. Read of same address issued in T+1 returns OLD data; consumers compare
//    oInFlightAddress when oInFlightValid and stall one cycle.
//  - Full rate: one write per cycle sustained; equal-priority requesters alternate strictly.
//  - Pointer wrap: NUM_REQ-1 -> 0. Lock bit ignored when request is 0.
// TESTING
//  1 Reset, all 4 requesting constantly, no lock -> grants 0,1,2,3,0,... one per cycle; RAM
//    enable high from cycle 2, addresses follow requester slices.
//  2 Only req2 (addr 0x05, data 0xA5) one cycle -> grant[2] cycle T; T+1 enable=1, addr=0x05,
//    oInFlight 0x05; T+2 enable=0; RAM readback 0xA5.
//  3 req1 locks 3 beats (lock=1,1,0) while req0,req3 wait -> grants 1,1,1 then 3 then 0
//    (pointer=1); oLocked high for 2 cycles after first beat.
//  4 Locked owner req2 drops request 2 cycles, req0 pending -> no grant, enable=0 those cycles;
//    req2 last beat -> req0 granted next cycle.
//  5 Reset asserted mid-lock -> next cycle oLocked=0, enable=0, grants 0; after release req0
//    wins even if req3 also requests.
//  6 Write addr 0x10 granted in T, read port0 addr 0x10 in T+1 -> old value; read in T+2 -> new.

Source files
------------

// File: rtl/ram_write_port_arbiter.sv
// Round-robin arbiter for the single RAM write port, with locked bursts.
// It registers the winning write toward the RAM and exports it as the in-flight write for RAW stalls.
module ram_write_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               iWriteRequest,
  input  logic [NUM_REQ-1:0]               iWriteLock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    iWriteAddress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    iWriteData,
  output logic [NUM_REQ-1:0]               oWriteGrant,
  output logic                             oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0]            oRamWriteAddress,
  output logic [DATA_WIDTH-1:0]            oRamDataIn,
  output logic                             oInFlightValid,
  output logic [ADDR_WIDTH-1:0]            oInFlightAddress,
  output logic                             oLocked,
  output logic [IDX_W-1:0]                 oOwner
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      pointer;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_lock;

  // Grant is a pure function of state and the current requests; reset masks it.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    grant_any   = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    oWriteGrant = '0;
    if (Reset) begin
      if (state == ST_LOCKED) begin
        grant_any = iWriteRequest[oOwner];
        grant_idx = oOwner;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IDX_W'((int'(pointer) + k) % NUM_REQ);
          if (!grant_any && iWriteRequest[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
    if (grant_any) oWriteGrant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oWriteGrant[i]) begin
        sel_addr = iWriteAddress[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = iWriteData[i*DATA_WIDTH +: DATA_WIDTH];
        sel_lock = iWriteLock[i];
      end
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      state            <= ST_ARB;
      pointer          <= IDX_W'(NUM_REQ - 1);
      oOwner           <= '0;
      oRamWriteEnable  <= 1'b0;
      oRamWriteAddress <= '0;
      oRamDataIn       <= '0;
    end else if (grant_any) begin
      pointer          <= grant_idx;
      oOwner           <= grant_idx;
      oRamWriteEnable  <= 1'b1;
      oRamWriteAddress <= sel_addr;
      oRamDataIn       <= sel_data;
      // The same rule both enters a burst and ends it on a beat with the lock bit clear.
      state            <= sel_lock ? ST_LOCKED : ST_ARB;
    end else begin
      oRamWriteEnable  <= 1'b0;
    end
  end

  assign oLocked          = (state == ST_LOCKED);
  assign oInFlightValid   = oRamWriteEnable;
  assign oInFlightAddress = oRamWriteAddress;

endmodule

// File: tb/tb_ram_write_port_arbiter.sv
// Bench for ram_write_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_ram_write_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] waddr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    grant;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic            if_valid;
  logic [AW-1:0]   if_addr;
  logic            locked;
  logic [IW-1:0]   owner;

  int checks = 0;
  int errors = 0;

  ram_write_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(clk), .Reset(rst_n),
    .iWriteRequest(req), .iWriteLock(lock), .iWriteAddress(waddr), .iWriteData(wdata),
    .oWriteGrant(grant), .oRamWriteEnable(we), .oRamWriteAddress(addr), .oRamDataIn(data),
    .oInFlightValid(if_valid), .oInFlightAddress(if_addr), .oLocked(locked), .oOwner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple RAM standing in for RAM_DUAL_READ_PORT: write at edge, registered read.
  logic [DW-1:0] tb_ram [256];
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  always @(posedge clk) begin
    if (we) tb_ram[addr] <= data;
    rd_data <= tb_ram[rd_addr];
  end

  // ---------------- behavioural model ----------------
  int            m_ptr = N - 1;
  int            m_owner = 0;
  bit            m_locked = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_last_grant = -1;
  bit            model_ready = 1'b0;

  // Who should be granted right now: a locked owner only, otherwise first requester after the pointer.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    g = exp_grant();
    m_last_grant <= g;
    if (!rst_n) begin
      m_ptr <= N - 1; m_owner <= 0; m_locked <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_data <= '0; model_ready <= 1'b1;
    end else if (g >= 0) begin
      m_ptr <= g; m_owner <= g; m_we <= 1'b1; m_locked <= lock[g];
      m_addr <= waddr[g*AW +: AW]; m_data <= wdata[g*DW +: DW];
    end else begin
      m_we <= 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    int eg;
    logic [N-1:0] ev;
    if (model_ready) begin
      eg = exp_grant();
      ev = '0;
      if (eg >= 0) ev[eg] = 1'b1;
      check("grant", 32'(grant), 32'(ev));
      check("wr_en", 32'(we), 32'(m_we));
      check("inflight_valid", 32'(if_valid), 32'(m_we));
      if (m_we) begin
        check("wr_addr", 32'(addr), 32'(m_addr));
        check("wr_data", 32'(data), 32'(m_data));
        check("inflight_addr", 32'(if_addr), 32'(m_addr));
      end
      check("locked", 32'(locked), 32'(m_locked));
      check("owner", 32'(owner), 32'(m_owner));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit r, input bit l, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = r;
    lock[i] = l;
    waddr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req = '0; lock = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  bit            pending [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_data  [N];
  bit            p_lock  [N];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; req = '0; lock = '0; waddr = '0; wdata = '0; rd_addr = '0;
    tick(); tick();

    // 1: reset state, grant masked during reset, then strict rotation 0,1,2,3,...
    check("rst_we", 32'(we), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(8'h20 + i), DW'(16'h0100 + i));
    #1;
    check("rst_grant_masked", 32'(grant), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", 32'(grant), 32'(1 << (k % N)));
      tick();
      check("rr_we", 32'(we), 32'd1);
      check("rr_addr", 32'(addr), 32'(8'h20 + (k % N)));
      check("rr_owner", 32'(owner), 32'(k % N));
    end
    clear_all();

    // 2: single write from requester 2
    set_req(2, 1'b1, 1'b0, 8'h05, 16'h00A5);
    #1;
    check("single_grant", 32'(grant), 32'b0100);
    tick();
    clear_all();
    #1;
    check("single_we", 32'(we), 32'd1);
    check("single_addr", 32'(addr), 32'h05);
    check("single_data", 32'(data), 32'h00A5);
    check("single_inflight", 32'(if_addr), 32'h05);
    tick();
    check("single_we_off", 32'(we), 32'd0);
    check("single_ram", 32'(tb_ram[5]), 32'h00A5);

    // 3: requester 1 locks three beats while 0 and 3 wait
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h30, 16'h3000);
    #1;
    tick();
    set_req(1, 1'b1, 1'b1, 8'h31, 16'h3100);
    set_req(3, 1'b1, 1'b0, 8'h33, 16'h3300);
    #1;
    check("lock_b1_grant", 32'(grant), 32'b0010);
    tick();
    check("lock_b1_locked", 32'(locked), 32'd1);
    check("lock_b2_grant", 32'(grant), 32'b0010);
    tick();
    check("lock_b2_locked", 32'(locked), 32'd1);
    set_req(1, 1'b1, 1'b0, 8'h32, 16'h3200);
    #1;
    check("lock_b3_grant", 32'(grant), 32'b0010);
    tick();
    check("lock_b3_unlocked", 32'(locked), 32'd0);
    req[1] = 1'b0;
    #1;
    check("lock_after_grant3", 32'(grant), 32'b1000);
    tick();
    req[3] = 1'b0;
    #1;
    check("lock_after_grant0", 32'(grant), 32'b0001);
    tick();
    clear_all();

    // 4: locked owner goes idle for two cycles, requester 0 must wait
    do_reset();
    set_req(2, 1'b1, 1'b1, 8'h40, 16'h4000);
    #1;
    check("idle_first_grant", 32'(grant), 32'b0100);
    tick();
    req[2] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h41, 16'h4100);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("idle_no_grant", 32'(grant), 32'd0);
      tick();
      check("idle_we_off", 32'(we), 32'd0);
      check("idle_still_locked", 32'(locked), 32'd1);
    end
    set_req(2, 1'b1, 1'b0, 8'h42, 16'h4200);
    #1;
    check("idle_last_beat", 32'(grant), 32'b0100);
    tick();
    req[2] = 1'b0;
    #1;
    check("idle_then_req0", 32'(grant), 32'b0001);
    tick();
    clear_all();

    // 5: reset in the middle of a lock
    do_reset();
    set_req(1, 1'b1, 1'b1, 8'h50, 16'h5000);
    #1;
    tick();
    check("midlock_locked", 32'(locked), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midlock_grant_masked", 32'(grant), 32'd0);
    tick();
    check("midlock_locked_cleared", 32'(locked), 32'd0);
    check("midlock_we_cleared", 32'(we), 32'd0);
    rst_n = 1'b1;
    req[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h51, 16'h5100);
    set_req(3, 1'b1, 1'b0, 8'h53, 16'h5300);
    #1;
    check("midlock_req0_wins", 32'(grant), 32'b0001);
    tick();
    clear_all();

    // 6: read-after-write hazard window
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h10, 16'h0033);
    tick();
    clear_all();
    tick();
    set_req(0, 1'b1, 1'b0, 8'h10, 16'h0077);
    tick();
    clear_all();
    rd_addr = 8'h10;
    #1;
    check("raw_inflight_valid", 32'(if_valid), 32'd1);
    check("raw_inflight_addr", 32'(if_addr), 32'h10);
    tick();
    check("raw_read_old", 32'(rd_data), 32'h0033);
    tick();
    check("raw_read_new", 32'(rd_data), 32'h0077);

    // Randomized traffic: requests held until granted, random locks and occasional reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    clear_all();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_last_grant >= 0) pending[m_last_grant] = 1'b0;
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          p_addr[i]  = AW'($urandom);
          p_data[i]  = DW'($urandom);
          p_lock[i]  = ($urandom_range(0, 2) == 0);
        end
        set_req(i, pending[i], p_lock[i] & ($urandom_range(0, 3) != 0 || pending[i]),
                p_addr[i], p_data[i]);
      end
      tick();
    end

    clear_all();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
